mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Sequential shift-and-add multiplier controller for the 4x4 multiplier datapath.
- Accepts one operand pair per start handshake.
- Each step, it drives the mux select from the current multiplier bit to choose between zero and the shifted multiplicand, then accumulates the result.
- Produces a 2N-bit product with a one-cycle done pulse.
- Sits between the operand source (switches/host logic) and the product display/consumer.

Parameters:
N, 4, operand width in bits; product width is 2N; N >= 2.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request to begin a multiply; sampled only in IDLE
a  input  N  multiplicand, captured on accepted start
b  input  N  multiplier, captured on accepted start
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse when product is valid
sel  output  1  mux select driven to datapath: current multiplier bit in RUN, 0 otherwise
step  output  clog2(N)  current bit index being processed in RUN, 0 otherwise
product  output  2N  result register; holds last completed product

Behaviour:
- Reset values (rst high at a clock edge): state=IDLE, busy=0, done=0, sel=0, step=0, product=0, internal a_reg/b_reg/acc/count=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - If start=1: a_reg<=a, b_reg<=b, acc<=0, count<=0, go RUN.
  - Else remain in IDLE.
- RUN:
  - busy=1.
  - sel = b_reg[count] (combinational from registered state); step = count.
  - Each cycle: acc <= acc + (sel ? (zero-extend(a_reg) << count) : 0), computed 2N bits wide, no overflow possible.
  - If count==N-1: go DONE. Else count<=count+1.
- DONE:
  - busy=1, done=1 for exactly this cycle, product<=acc (registered).
  - Next state IDLE unconditionally.
- Latency: start sampled at edge E0 -> RUN during cycles E0+1..E0+N -> DONE (done=1) during cycle after edge E0+N+1.
  - For N=4, done is high 5 cycles after the start edge.
  - The product register updates at the edge that leaves DONE.
  - Alternative allowed only if product is valid while done=1: load product at the DONE-entry edge with the final accumulated value. Required: product equals final result whenever done=1.
- Throughput: next start is accepted no earlier than the cycle after done (IDLE); one multiply per N+2 cycles.
- start while busy=1 (RUN or DONE): ignored, not queued.
- start held high continuously: a new operation is accepted each time IDLE is reached.
- Operands a/b changing during RUN: no effect; only captured values are used.
- Reset mid-operation (RUN or DONE): immediate return to IDLE at that edge.
  - No done pulse is emitted.
  - product is cleared to 0 by the reset.
- rst and start asserted together: rst wins.
- b=0 or a=0: still takes full N RUN cycles; product=0.
- product is unchanged between done pulses.

Test Plan:
- Reset then idle: rst high 2 cycles, start=0 -> busy=0, done=0, sel=0, step=0, product=0x00 throughout.
- Basic multiply: a=13, b=11, start pulse 1 cycle -> busy rises next cycle; sel sequence over steps 0..3 = 1,1,0,1; done high exactly one cycle, 5 cycles after the start edge; product=0x8F (143), held afterwards.
- Corners:
  - a=15, b=15 -> product=0xE1 (225).
  - a=0, b=9 -> product=0x00 with sel sequence 1,0,0,1.
  - a=1, b=15 -> product=0x0F.
  - Each done pulse arrives after the same 5-cycle latency.
- Start while busy: start=1 at cycle 2 of RUN with a=3, b=3 and different first operands (a=6, b=7) -> ignored; product=42; no second done pulse until a new start in IDLE.
- Reset mid-run: start a=5, b=5, assert rst during step 2 -> next cycle busy=0, done never pulses, product=0.
- Back-to-back: start held high, operands 2x3 then 4x4 -> done pulses with product=6 then product=16, separated by 6 cycles.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier controller: one N x N operand pair per
// start handshake, N accumulate steps, 2N-bit product with a one-cycle done pulse.
module mult_seq_ctrl #(
  parameter int N = 4,
  localparam int CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  output logic            busy,
  output logic            done,
  output logic            sel,
  output logic [CW-1:0]   step,
  output logic [2*N-1:0]  product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic [2*N-1:0]  acc;
  logic [CW-1:0]   count;
  logic [2*N-1:0]  acc_next;

  // Partial product for one step: zero, or the multiplicand shifted into place.
  function automatic logic [2*N-1:0] partial(input logic [N-1:0] mcand,
                                             input logic [CW-1:0] shift,
                                             input logic bit_sel);
    logic [2*N-1:0] ext;
    ext = {{N{1'b0}}, mcand};
    return bit_sel ? (ext << shift) : '0;
  endfunction

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign sel      = (state == RUN) ? b_reg[count] : 1'b0;
  assign step     = (state == RUN) ? count : '0;
  assign acc_next = acc + partial(a_reg, count, sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          // Product is loaded on entry to DONE so it is already valid while done=1.
          if (count == LAST) begin
            product <= acc_next;
            state   <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          product <= acc;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl (N=4): vector table plus hand-written
// sequences for busy-start, mid-run reset and back-to-back operation.
module tb_mult_seq_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          busy;
  logic          done;
  logic          sel;
  logic [1:0]    step;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  mult_seq_ctrl #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sel     (sel),
    .step    (step),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
    logic [3:0] sel_seq;  // bit i = expected sel at step i
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Full operation from a start pulse, checking every cycle up to the idle after done.
  task automatic run_mult(input logic [3:0] va, input logic [3:0] vb,
                          input logic [7:0] vp, input logic [3:0] vs);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_step", step, i);
      chk("run_sel", sel, vs[i]);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_product", product, vp);
    chk("done_sel", sel, 0);
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_product", product, vp);
    @(negedge clk);
    chk("hold_product", product, vp);
  endtask

  int d_first, d_second, n_done;
  logic [7:0] p_first, p_second;

  initial begin
    vecs[0] = '{a: 4'd13, b: 4'd11, prod: 8'h8F, sel_seq: 4'b1011};
    vecs[1] = '{a: 4'd15, b: 4'd15, prod: 8'hE1, sel_seq: 4'b1111};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  prod: 8'h00, sel_seq: 4'b1001};
    vecs[3] = '{a: 4'd1,  b: 4'd15, prod: 8'h0F, sel_seq: 4'b1111};
    vecs[4] = '{a: 4'd9,  b: 4'd6,  prod: 8'h36, sel_seq: 4'b0110};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    // Reset then idle
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sel", sel, 0);
      chk("rst_step", step, 0);
      chk("rst_product", product, 0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_product", product, 0);
    end

    foreach (vecs[i]) run_mult(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].sel_seq);

    // rst together with start: reset wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 4'd3; b = 4'd3;
    @(negedge clk);
    chk("rst_start_busy", busy, 0);
    chk("rst_start_product", product, 0);
    rst = 1'b0; start = 1'b0;

    // Start while busy is ignored
    @(negedge clk);
    a = 4'd6; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd3; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_step", step, 2);
    @(negedge clk);
    chk("busy_start_nodone", done, 0);
    @(negedge clk);
    chk("busy_start_done", done, 1);
    chk("busy_start_product", product, 42);
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("busy_start_no_second_done", n_done, 0);
    chk("busy_start_hold", product, 42);

    // Reset mid-run during step 2
    @(negedge clk);
    a = 4'd5; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_step", step, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_product", product, 0);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    chk("midrst_product_hold", product, 0);

    // Back-to-back with start held high
    @(negedge clk);
    a = 4'd2; b = 4'd3; start = 1'b1;
    @(negedge clk);
    a = 4'd4; b = 4'd4;
    n_done = 0; d_first = 0; d_second = 0; p_first = '0; p_second = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (done) begin
        n_done++;
        if (n_done == 1) begin d_first = cyc; p_first = product; end
        if (n_done == 2) begin d_second = cyc; p_second = product; end
      end
      if (cyc < 12) @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_done_count", n_done, 2);
    chk("b2b_first_latency", d_first, 5);
    chk("b2b_first_product", p_first, 6);
    chk("b2b_second_product", p_second, 16);
    chk("b2b_gap", d_second - d_first, 6);
    @(negedge clk);
    chk("b2b_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
